lut_neuron_arbiter: RTL
=======================

Name: lut_neuron_arbiter

Overview:
- Shares one runtime-programmable neuron truth table (2^IN_BITS entries × OUT_BITS, distributed RAM) between NUM_REQ lookup requesters.
- Arbitrates requesters round-robin and serves one lookup per cycle with registered response.
- Sequences table (re)loading from a config stream.
- Sits between layer-input gather logic and the layer output register, replacing per-neuron hard-coded LUT ROMs where weights must be reloadable.

Parameters:
- NUM_REQ, 4, number of lookup requesters (≥2).
- IN_BITS, 8, table address width (neuron fan-in bits).
- OUT_BITS, 2, table entry width (neuron output bits).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_addr  in  NUM_REQ*IN_BITS  per-requester address; requester i occupies bits [i*IN_BITS +: IN_BITS].
- req_ready  out  NUM_REQ  one-hot grant; lookup accepted when valid&ready.
- rsp_valid  out  NUM_REQ  one-hot; response for requester i.
- rsp_data  out  OUT_BITS  table entry for the responding requester.
- cfg_valid  in  1  config write strobe.
- cfg_addr  in  IN_BITS  table entry index.
- cfg_data  in  OUT_BITS  entry value.
- cfg_last  in  1  marks final write of a load.
- cfg_ready  out  1  config write accepted when valid&ready.
- table_loaded  out  1  table holds a complete load.
- busy  out  1  lookup response in flight or load in progress.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, cfg_ready=1, table_loaded=0, busy=0.
  - State=S_EMPTY; RR pointer=0.
  - Table contents are not cleared.
- FSM states: S_EMPTY, S_LOADING, S_READY.
  - S_EMPTY: cfg_ready=1, req_ready=0. Accepted cfg write → S_LOADING, or S_READY if cfg_last.
  - S_LOADING: cfg_ready=1, req_ready=0, busy=1. Accepted write with cfg_last=1 → S_READY. table_loaded rises the cycle after that write.
  - S_READY: table_loaded=1. An accepted cfg write here starts a reload:
    - state → S_LOADING, or stays S_READY if that write has cfg_last.
    - table_loaded drops the next cycle.
- Config priority: in S_READY, if cfg_valid=1, req_ready is all zero that cycle and the write is accepted. Lookups never share a cycle with a write.
- Writes are visible to lookups accepted on the following cycle and later.
- Arbitration (S_READY, cfg_valid=0):
  - Grant goes to the first valid requester at or after the RR pointer, wrapping NUM_REQ-1→0.
  - req_ready is combinational from req_valid and the pointer, and is zero when no request is valid.
  - After a grant to requester g, the pointer becomes (g+1) mod NUM_REQ. The pointer holds when nothing is granted.
- Lookup latency: the table is read on the accept cycle. rsp_valid[g]=1 and rsp_data=table[addr] exactly one cycle later, for one cycle.
  - Sustained throughput is one lookup per cycle.
  - rsp_data holds its last value when rsp_valid=0.
- No backpressure on responses; requesters must accept.
- A response in flight when a reload begins is still delivered, with the pre-write data.
- busy = (state==S_LOADING) | (|rsp_valid).
- Reset mid-load: returns to S_EMPTY; the partial table is treated as invalid until a full load completes.
- cfg_last without any preceding writes is legal: a single-write load.

Optional Feature:
- Macro: LUT_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], reset 0.
  - Increments each cycle where req_valid is nonzero and no lookup is accepted. This includes cycles stalled by S_EMPTY, S_LOADING or config priority.
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package lut_arb_pkg:
  - state enum (S_EMPTY, S_LOADING, S_READY).
  - Default IN_BITS/OUT_BITS constants.
  - TABLE_DEPTH = 1<<IN_BITS.
- Sub-module lut_rr_arbiter: NUM_REQ-wide round-robin grant with pointer register and enable input. The top instantiates it once.

Test Plan:
- Reset, then req_valid=4'b1111 with no load → req_ready=0 throughout, table_loaded=0. With the feature enabled, stall_cnt counts those cycles.
- Load 256 writes with table[a]=a[1:0], cfg_last on the 256th → table_loaded=1 the next cycle. Requester 2 then looks up addr 8'h37 → rsp_valid=4'b0100 one cycle later, rsp_data=2'b11.
- All four requesters valid continuously with distinct addrs → grants in order 0,1,2,3,0,…, one per cycle, each rsp matching its addr[1:0].
- Only requesters 1 and 3 valid, pointer at 2 → grant 3, then 1, then 3.
- In S_READY, cfg_valid with addr 8'h05 data 2'b10 and cfg_last=1 while requester 0 is valid → no grant that cycle. Next-cycle lookup of 8'h05 returns 2'b10, and table_loaded stays 1.
- Reload started mid-stream (cfg_last=0) with a lookup already in flight → the in-flight response carries the old entry, table_loaded=0 the next cycle, and req_ready=0 until cfg_last.

Source files
------------

// File: rtl/lut_arb_pkg.sv
// Shared types and defaults for the reloadable LUT neuron arbiter.
// Optional stall counter is enabled by defining LUT_ARB_STALL_CNT_EN.
package lut_arb_pkg;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_READY   = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_IN_BITS  = 8;
  localparam int DEF_OUT_BITS = 2;
  localparam int TABLE_DEPTH  = 1 << DEF_IN_BITS;

  function automatic int table_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/lut_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer moves past the
// winner on every grant and holds otherwise. Grants are suppressed when en=0.
module lut_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_reg;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_reg) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (found) begin
      ptr_reg <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/lut_neuron_arbiter.sv
// One runtime-loadable neuron truth table shared round-robin by NUM_REQ
// lookup ports. Define LUT_ARB_STALL_CNT_EN to add the stall_cnt output.
module lut_neuron_arbiter
  import lut_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*IN_BITS-1:0]  req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [OUT_BITS-1:0]         rsp_data,
  input  logic                        cfg_valid,
  input  logic [IN_BITS-1:0]          cfg_addr,
  input  logic [OUT_BITS-1:0]         cfg_data,
  input  logic                        cfg_last,
  output logic                        cfg_ready,
  output logic                        table_loaded,
`ifdef LUT_ARB_STALL_CNT_EN
  output logic [15:0]                 stall_cnt,
`endif
  output logic                        busy
);

  localparam int DEPTH = table_depth(IN_BITS);
  localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state_reg, state_next;
  logic [OUT_BITS-1:0] mem [DEPTH];
  logic [IN_BITS-1:0]  addr_arr [NUM_REQ];
  logic [PW-1:0]       grant_idx;
  logic                arb_en;
  logic                lookup_fire;
  logic                cfg_fire;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[gi*IN_BITS +: IN_BITS];
  end

  // Config writes always win, so a lookup can never race a table write.
  assign cfg_ready   = 1'b1;
  assign cfg_fire    = cfg_valid & cfg_ready;
  assign arb_en      = (state_reg == S_READY) && !cfg_valid;
  assign lookup_fire = |req_ready;

  lut_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_next = state_reg;
    if (cfg_fire) state_next = cfg_last ? S_READY : S_LOADING;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_EMPTY;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      table_loaded <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rsp_valid    <= req_ready;
      if (lookup_fire) rsp_data <= mem[addr_arr[grant_idx]];
      table_loaded <= (state_next == S_READY);
      busy         <= (state_next == S_LOADING) | lookup_fire;
    end
  end

  // Table storage is deliberately not reset; validity is tracked by the FSM.
  always_ff @(posedge clk) begin
    if (cfg_fire) mem[cfg_addr] <= cfg_data;
  end

`ifdef LUT_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((|req_valid) && !lookup_fire && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
